// File: rtl/turing_pkg.sv
// Shared types for the multi-symbol Turing machine: phases, faults, step
// substates, head-move encoding and the default program-table entry layout.
package turing_pkg;

  typedef enum logic [1:0] {
    PH_PROG = 2'b00,
    PH_TAPE = 2'b01,
    PH_RUN  = 2'b10,
    PH_HALT = 2'b11
  } phase_e;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'b00,
    FLT_LEFT    = 2'b01,
    FLT_RIGHT   = 2'b10,
    FLT_TIMEOUT = 2'b11
  } fault_e;

  typedef enum logic {
    SUB_FETCH = 1'b0,
    SUB_EXEC  = 1'b1
  } sub_e;

  localparam logic [1:0] DIR_STAY     = 2'b00;
  localparam logic [1:0] DIR_RIGHT    = 2'b01;
  localparam logic [1:0] DIR_LEFT     = 2'b10;
  localparam logic [1:0] DIR_STAY_ALT = 2'b11;

  localparam int TM_SYM_W = 2;
  localparam int TM_SW    = 3;

  typedef struct packed {
    logic [TM_SYM_W-1:0] write_sym;
    logic [1:0]          dir;
    logic [TM_SW-1:0]    next_state;
  } entry_t;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for a button-style level input; the one-cycle strobe
// is registered so the consumer acts one cycle after the edge is sampled.
module edge_pulse (
  input  logic clock,
  input  logic reset_n,
  input  logic level,
  output logic pulse
);

  logic level_r;
  logic pulse_r;

  // Delayed copy of the level and the registered rising-edge strobe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      level_r <= level;
      pulse_r <= level & ~level_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/turing_machine_multi.sv
// Multi-symbol Turing machine core: button-driven program/tape load, two-cycle
// FETCH/EXEC steps in free-run or single-step mode, halt/fault detection.
module turing_machine_multi
  import turing_pkg::*;
#(
  parameter int NUM_STATES = 8,
  parameter int SYM_W      = TM_SYM_W,
  parameter int TAPE_LEN   = 64,
  parameter int MAX_STEPS  = 4096,
  parameter int SW         = $clog2(NUM_STATES),
  parameter int AW         = $clog2(TAPE_LEN),
  parameter int ENTRY_W    = SYM_W + 2 + SW,
  parameter int CW         = $clog2(MAX_STEPS + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [ENTRY_W-1:0] input_data,
  input  logic               next,
  input  logic               done,
  input  logic               run_mode,
  output logic [1:0]         phase,
  output logic [SW-1:0]      state_out,
  output logic [AW-1:0]      head_addr,
  output logic [SYM_W-1:0]   head_sym,
  output logic [SYM_W-1:0]   read_sym,
  output logic [CW-1:0]      step_count,
  output logic               compute_done,
  output logic [1:0]         fault
);

  localparam int TBL_N = NUM_STATES * (2 ** SYM_W);
  localparam int TW    = SW + SYM_W;
  localparam int WP_MX = (TBL_N > TAPE_LEN) ? TBL_N : TAPE_LEN;
  localparam int WPW   = $clog2(WP_MX + 1);

  typedef struct packed {
    logic [SYM_W-1:0] write_sym;
    logic [1:0]       dir;
    logic [SW-1:0]    next_state;
  } tbl_entry_t;

  logic [ENTRY_W-1:0] table_r [TBL_N];
  logic [SYM_W-1:0]   tape_r  [TAPE_LEN];

  phase_e     phase_r;
  sub_e       sub_r;
  fault_e     fault_r;
  tbl_entry_t entry_r;
  logic [SW-1:0]  state_r;
  logic [AW-1:0]  head_r;
  logic [AW-1:0]  read_addr_r;
  logic [CW-1:0]  step_r;
  logic [WPW-1:0] wptr_r;
  logic           done_flag_r;

  logic           next_raw_s;
  logic           done_p_s;
  logic           next_p_s;
  logic [SYM_W-1:0] head_sym_s;
  logic [TW-1:0]  tbl_widx_s;
  logic [AW-1:0]  tape_widx_s;
  logic [AW-1:0]  move_head_s;
  fault_e         edge_fault_s;
  logic           halt_s;
  fault_e         halt_fault_s;

  edge_pulse u_next_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .level   (next),
    .pulse   (next_raw_s)
  );

  edge_pulse u_done_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .level   (done),
    .pulse   (done_p_s)
  );

  // A simultaneous done edge suppresses next
  assign next_p_s    = next_raw_s & ~done_p_s;
  assign head_sym_s  = tape_r[head_r];
  assign tbl_widx_s  = wptr_r[TW-1:0];
  assign tape_widx_s = wptr_r[AW-1:0];

  // Head movement for the fetched entry, blocked at either tape edge
  always_comb begin
    move_head_s  = head_r;
    edge_fault_s = FLT_NONE;
    case (entry_r.dir)
      DIR_RIGHT: begin
        if (head_r == AW'(TAPE_LEN - 1)) begin
          edge_fault_s = FLT_RIGHT;
        end else begin
          move_head_s = head_r + AW'(1'b1);
        end
      end
      DIR_LEFT: begin
        if (head_r == {AW{1'b0}}) begin
          edge_fault_s = FLT_LEFT;
        end else begin
          move_head_s = head_r - AW'(1'b1);
        end
      end
      default: begin
        move_head_s  = head_r;
        edge_fault_s = FLT_NONE;
      end
    endcase
  end

  // Halt decision for the executing step: halt state, then edges, then step limit
  always_comb begin
    halt_s       = 1'b0;
    halt_fault_s = FLT_NONE;
    if (entry_r.next_state == SW'(NUM_STATES - 1)) begin
      halt_s       = 1'b1;
      halt_fault_s = FLT_NONE;
    end else if (edge_fault_s != FLT_NONE) begin
      halt_s       = 1'b1;
      halt_fault_s = edge_fault_s;
    end else if (step_r == CW'(MAX_STEPS - 1)) begin
      halt_s       = 1'b1;
      halt_fault_s = FLT_TIMEOUT;
    end else begin
      halt_s       = 1'b0;
      halt_fault_s = FLT_NONE;
    end
  end

  // Phase sequencer, step engine and table/tape writes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_r     <= PH_PROG;
      sub_r       <= SUB_FETCH;
      fault_r     <= FLT_NONE;
      entry_r     <= '0;
      state_r     <= '0;
      head_r      <= '0;
      read_addr_r <= '0;
      step_r      <= '0;
      wptr_r      <= '0;
      done_flag_r <= 1'b0;
      for (int i = 0; i < TBL_N; i++) table_r[i] <= '0;
      for (int i = 0; i < TAPE_LEN; i++) tape_r[i] <= '0;
    end else begin
      case (phase_r)
        PH_PROG: begin
          if (done_p_s) begin
            phase_r <= PH_TAPE;
            wptr_r  <= '0;
          end else if (next_p_s && (wptr_r < WPW'(TBL_N))) begin
            table_r[tbl_widx_s] <= input_data;
            wptr_r              <= wptr_r + WPW'(1'b1);
          end
        end
        PH_TAPE: begin
          if (done_p_s) begin
            phase_r <= PH_RUN;
            sub_r   <= SUB_FETCH;
            state_r <= '0;
            head_r  <= '0;
            step_r  <= '0;
            fault_r <= FLT_NONE;
          end else if (next_p_s && (wptr_r < WPW'(TAPE_LEN))) begin
            tape_r[tape_widx_s] <= input_data[SYM_W-1:0];
            wptr_r              <= wptr_r + WPW'(1'b1);
          end
        end
        PH_RUN: begin
          if (sub_r == SUB_FETCH) begin
            if (run_mode || next_p_s) begin
              entry_r <= tbl_entry_t'(table_r[{state_r, head_sym_s}]);
              sub_r   <= SUB_EXEC;
            end
          end else begin
            tape_r[head_r] <= entry_r.write_sym;
            state_r        <= entry_r.next_state;
            head_r         <= move_head_s;
            step_r         <= step_r + CW'(1'b1);
            sub_r          <= SUB_FETCH;
            if (halt_s) begin
              phase_r     <= PH_HALT;
              fault_r     <= halt_fault_s;
              read_addr_r <= '0;
              done_flag_r <= 1'b1;
            end
          end
        end
        PH_HALT: begin
          if (done_p_s) begin
            phase_r     <= PH_TAPE;
            wptr_r      <= '0;
            done_flag_r <= 1'b0;
          end else if (next_p_s) begin
            read_addr_r <= (read_addr_r == AW'(TAPE_LEN - 1)) ? {AW{1'b0}}
                                                               : read_addr_r + AW'(1'b1);
          end
        end
        default: phase_r <= PH_PROG;
      endcase
    end
  end

  assign phase        = phase_r;
  assign state_out    = state_r;
  assign head_addr    = head_r;
  assign head_sym     = head_sym_s;
  assign read_sym     = tape_r[read_addr_r];
  assign step_count   = step_r;
  assign compute_done = done_flag_r;
  assign fault        = fault_r;

endmodule

// File: tb/tb_turing_machine_multi.sv
// Directed bench for turing_machine_multi: default instance plus a MAX_STEPS=16
// instance sharing stimulus, checked against hand-computed values.
module tb_turing_machine_multi;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       next = 1'b0;
  logic       done = 1'b0;
  logic       run_mode = 1'b1;
  logic [6:0] input_data = 7'd0;

  logic [1:0]  phase, fault, phase16, fault16;
  logic [2:0]  state_out, state16;
  logic [5:0]  head_addr, head16;
  logic [1:0]  head_sym, read_sym, head_sym16, read_sym16;
  logic [12:0] step_count;
  logic [4:0]  step16;
  logic        compute_done, done16;

  int checks = 0;
  int errors = 0;

  turing_machine_multi dut (
    .clock(clock), .reset_n(reset_n), .input_data(input_data), .next(next),
    .done(done), .run_mode(run_mode), .phase(phase), .state_out(state_out),
    .head_addr(head_addr), .head_sym(head_sym), .read_sym(read_sym),
    .step_count(step_count), .compute_done(compute_done), .fault(fault)
  );

  turing_machine_multi #(.MAX_STEPS(16)) dut16 (
    .clock(clock), .reset_n(reset_n), .input_data(input_data), .next(next),
    .done(done), .run_mode(run_mode), .phase(phase16), .state_out(state16),
    .head_addr(head16), .head_sym(head_sym16), .read_sym(read_sym16),
    .step_count(step16), .compute_done(done16), .fault(fault16)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_next();
    next = 1'b1;
    tick();
    next = 1'b0;
    tick();
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic load(input logic [6:0] d);
    input_data = d;
    pulse_next();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // {s0,sym0}={1,stay,7}, {s0,sym1}={1,R,0}; tape 1,1,1,0; ends in RUN
  task automatic load_incrementer();
    load(7'b01_00_111);
    load(7'b01_01_000);
    pulse_done();
    load(7'd1);
    load(7'd1);
    load(7'd1);
    load(7'd0);
    pulse_done();
  endtask

  task automatic wait_halt(input int budget);
    int cyc;
    cyc = 0;
    while (phase != 2'b11 && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_phase"}, phase, 0);
    check({pfx, "_state"}, state_out, 0);
    check({pfx, "_head"}, head_addr, 0);
    check({pfx, "_head_sym"}, head_sym, 0);
    check({pfx, "_read_sym"}, read_sym, 0);
    check({pfx, "_steps"}, step_count, 0);
    check({pfx, "_cdone"}, compute_done, 0);
    check({pfx, "_fault"}, fault, 0);
  endtask

  initial begin
    int n;
    int cyc;

    repeat (2) tick();
    check_zero("rst");
    reset_n = 1'b1;
    tick();

    // next and done together in PROG: done wins, table stays empty
    run_mode = 1'b0;
    input_data = 7'b10_10_101;
    next = 1'b1;
    done = 1'b1;
    tick();
    next = 1'b0;
    done = 1'b0;
    tick();
    tick();
    check("dual_phase", phase, 1);
    pulse_done();
    tick();
    check("dual_run_steps0", step_count, 0);
    pulse_next();
    tick();
    tick();
    check("dual_phase_run", phase, 2);
    check("dual_state", state_out, 0);
    check("dual_steps", step_count, 1);
    check("dual_fault", fault, 0);

    // free-run incrementer
    do_reset();
    run_mode = 1'b1;
    load_incrementer();
    wait_halt(60);
    check("inc_phase", phase, 3);
    check("inc_fault", fault, 0);
    check("inc_head", head_addr, 3);
    check("inc_steps", step_count, 4);
    check("inc_state", state_out, 7);
    check("inc_cdone", compute_done, 1);
    check("inc_head_sym", head_sym, 1);
    for (int i = 0; i <= 64; i++) begin
      check("read_sym", read_sym, ((i % 64) < 4) ? 1 : 0);
      pulse_next();
    end

    // asynchronous reset while in HALT
    reset_n = 1'b0;
    #1;
    check_zero("rst_halt");
    tick();
    reset_n = 1'b1;
    tick();

    // move left at cell 0
    load(7'b00_10_000);
    pulse_done();
    pulse_done();
    wait_halt(20);
    check("left_phase", phase, 3);
    check("left_fault", fault, 1);
    check("left_steps", step_count, 1);
    check("left_head", head_addr, 0);

    // step-limit timeout on the MAX_STEPS=16 instance
    do_reset();
    pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
    n = 0;
    while (phase16 != 2'b10 && n < 10) begin
      tick();
      n++;
    end
    cyc = 0;
    while (phase16 != 2'b11 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("to_cycles", cyc, 32);
    check("to_phase", phase16, 3);
    check("to_fault", fault16, 3);
    check("to_steps", step16, 16);
    check("to_default_running", phase, 2);
    check("to_default_steps", step_count, 16);

    // asynchronous reset mid-RUN
    reset_n = 1'b0;
    #1;
    check_zero("rst_run");
    tick();
    reset_n = 1'b1;
    tick();

    // single-step incrementer
    run_mode = 1'b0;
    load_incrementer();
    repeat (4) tick();
    check("ss_steps0", step_count, 0);
    check("ss_phase0", phase, 2);
    for (int k = 1; k <= 4; k++) begin
      pulse_next();
      tick();
      check("ss_steps", step_count, k);
      if (k < 4) begin
        check("ss_phase_run", phase, 2);
        repeat (4) tick();
        check("ss_stall", step_count, k);
      end else begin
        check("ss_phase_halt", phase, 3);
        check("ss_head", head_addr, 3);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
